acc8_seq: RTL and testbench

ACC8_SEQ -- requirements
Module: acc8_seq

---
 rtl/acc8_seq.sv | 111 +++++++++++
 tb/tb_acc8_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/acc8_seq.sv
// Frame accumulator: sums operand bytes through an external 8-bit adder and counts carry-outs.
// Define ACC8_SAT_EN to make the sum saturate at 8'hFF on the first carry of a frame.
module acc8_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    input  logic [7:0] add_s,
    input  logic       add_c,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic [3:0] out_ccnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state_reg, state_next;
    logic [7:0] acc_reg, acc_next;
    logic [3:0] ccnt_reg, ccnt_next;
    logic       out_valid_reg, out_valid_next;
    logic [7:0] out_sum_reg, out_sum_next;
    logic [3:0] out_ccnt_reg, out_ccnt_next;

    logic       xfer;
    logic [7:0] sum_val;
    logic [3:0] ccnt_inc;

    assign in_ready  = (state_reg != DONE);
    assign xfer      = in_valid & in_ready;
    assign add_a     = acc_reg;
    assign add_b     = in_data;
    assign add_cin   = 1'b0;
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_ccnt  = out_ccnt_reg;

`ifdef ACC8_SAT_EN
    // Once a carry occurs, 8'hFF plus any byte carries again (or stays FF for 0), so it sticks.
    assign sum_val = add_c ? 8'hFF : add_s;
`else
    assign sum_val = add_s;
`endif

    assign ccnt_inc = (add_c && (ccnt_reg != 4'hF)) ? ccnt_reg + 4'd1 : ccnt_reg;

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        ccnt_next      = ccnt_reg;
        out_valid_next = out_valid_reg;
        out_sum_next   = out_sum_reg;
        out_ccnt_next  = out_ccnt_reg;
        case (state_reg)
            IDLE, ACC: begin
                if (xfer) begin
                    acc_next  = sum_val;
                    ccnt_next = ccnt_inc;
                    if (in_last) begin
                        state_next     = DONE;
                        out_valid_next = 1'b1;
                        out_sum_next   = sum_val;
                        out_ccnt_next  = ccnt_inc;
                    end else begin
                        state_next = ACC;
                    end
                end
            end
            DONE: begin
                // Result handed off: clear everything so the next frame starts from zero.
                if (out_ready) begin
                    state_next     = IDLE;
                    acc_next       = 8'd0;
                    ccnt_next      = 4'd0;
                    out_valid_next = 1'b0;
                    out_sum_next   = 8'd0;
                    out_ccnt_next  = 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= 8'd0;
            ccnt_reg      <= 4'd0;
            out_valid_reg <= 1'b0;
            out_sum_reg   <= 8'd0;
            out_ccnt_reg  <= 4'd0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            ccnt_reg      <= ccnt_next;
            out_valid_reg <= out_valid_next;
            out_sum_reg   <= out_sum_next;
            out_ccnt_reg  <= out_ccnt_next;
        end
    end

endmodule

// File: tb/tb_acc8_seq.sv
// Scoreboard bench for acc8_seq: directed frames push expected results, a monitor pops on handshake.
// Expected values switch with ACC8_SAT_EN.
module tb_acc8_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_s;
    logic       add_c;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [3:0] out_ccnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_cyc = -1;
    logic prev_valid = 1'b0;
    logic [11:0] exp_q[$];

`ifdef ACC8_SAT_EN
    localparam logic [7:0] EXP_A = 8'd255;
    localparam logic [7:0] EXP_C = 8'd255;
`else
    localparam logic [7:0] EXP_A = 8'd14;
    localparam logic [7:0] EXP_C = 8'd239;
`endif

    acc8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_c     (add_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ccnt  (out_ccnt)
    );

    // External ripple adder behaviour: 9-bit sum of both operands and carry-in.
    assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: latency check on each new result, scoreboard compare on each handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && !prev_valid)
            check("latency", cyc, last_cyc);
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                $display("result sum=%0d ccnt=%0d (expect sum=%0d ccnt=%0d)",
                         out_sum, out_ccnt, e[11:4], e[3:0]);
                check("out_sum", int'(out_sum), int'(e[11:4]));
                check("out_ccnt", int'(out_ccnt), int'(e[3:0]));
            end
        end
        prev_valid <= out_valid;
    end

    // Called at posedge+1; returns at posedge+1 after the byte was taken.
    task automatic send(input logic [7:0] d, input logic last);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        if (last) last_cyc = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input logic [7:0] s, input logic [3:0] c);
        exp_q.push_back({s, c});
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 30) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ccnt", out_ccnt, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_add_cin", add_cin, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // {236, 34}
        send(8'd236, 1'b0); send(8'd34, 1'b1);
        expect_res(EXP_A, 4'd1);
        drain();

        // {99, 67}: no carry
        send(8'd99, 1'b0); send(8'd67, 1'b1);
        expect_res(8'd166, 4'd0);
        drain();

        // 17 x 255: carry count saturates
        for (int i = 0; i < 17; i++) send(8'd255, (i == 16));
        expect_res(EXP_C, 4'd15);
        drain();

        // {10, bubble, bubble, 20}
        send(8'd10, 1'b0);
        repeat (2) @(posedge clk); #1;
        send(8'd20, 1'b1);
        expect_res(8'd30, 4'd0);
        drain();

        // Backpressure hold with a pending operand that must not be consumed
        out_ready = 1'b0;
        send(8'd1, 1'b0); send(8'd2, 1'b1);
        expect_res(8'd3, 4'd0);
        in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_sum", out_sum, 3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("after_hs_out_valid", out_valid, 0);
        check("after_hs_in_ready", in_ready, 1);
        send(8'd7, 1'b1);
        expect_res(8'd7, 4'd0);
        drain();

        // Reset mid-frame
        send(8'd50, 1'b0);
        rst_n = 1'b0; #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_add_a", add_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        send(8'd5, 1'b1);
        expect_res(8'd5, 4'd0);
        drain();

        // Reset while a result is held
        out_ready = 1'b0;
        send(8'd200, 1'b1);
        @(posedge clk); #1;
        check("done_out_valid", out_valid, 1);
        rst_n = 1'b0; #1;
        check("donerst_out_valid", out_valid, 0);
        check("donerst_out_sum", out_sum, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("donerst_in_ready", in_ready, 1);
        send(8'd9, 1'b1);
        expect_res(8'd9, 4'd0);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
